// File: rtl/pkt_pkg.sv
// Shared constants, FSM state encoding and result-flag bundle for the
// downstream packet checker.
package pkt_pkg;

  localparam logic [15:0] HEAD_WORD_DEF = 16'h55D5;
  localparam logic [15:0] TAIL_WORD_DEF = 16'hAAAA;
  localparam int          MIN_LEN_DEF   = 4;
  localparam int          MAX_LEN_DEF   = 200;

  typedef logic [1:0] state_t;
  localparam state_t WAIT_GAP = 2'd0;
  localparam state_t IDLE     = 2'd1;
  localparam state_t PKT      = 2'd2;

  typedef struct packed {
    logic ok;
    logic head_err;
    logic tail_err;
    logic sum_err;
    logic short_pkt;
    logic long_pkt;
  } chk_flags_t;

  function automatic logic any_err(input chk_flags_t f);
    return f.head_err | f.tail_err | f.sum_err | f.short_pkt | f.long_pkt;
  endfunction

endpackage

// File: rtl/pkt_out_chk_if.sv
// Packet stream input, counter clear and checker results as one bundle.
interface pkt_out_chk_if;

  logic        vid_in;
  logic [15:0] data_in;
  logic        cnt_clr;
  logic        chk_ok;
  logic        chk_head_err;
  logic        chk_tail_err;
  logic        chk_sum_err;
  logic        chk_short_pkt;
  logic        chk_long_pkt;
  logic [31:0] chk_ok_cnt;
  logic [15:0] chk_err_cnt;
  logic [7:0]  chk_last_len;

  modport master (
    output vid_in, data_in, cnt_clr,
    input  chk_ok, chk_head_err, chk_tail_err, chk_sum_err,
           chk_short_pkt, chk_long_pkt, chk_ok_cnt, chk_err_cnt, chk_last_len
  );

  modport slave (
    input  vid_in, data_in, cnt_clr,
    output chk_ok, chk_head_err, chk_tail_err, chk_sum_err,
           chk_short_pkt, chk_long_pkt, chk_ok_cnt, chk_err_cnt, chk_last_len
  );

endinterface

// File: rtl/pkt_out_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment loads 1 so that event is still counted.
module sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? ONE : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/pkt_out_chk.sv
// Downstream packet checker: framing, length and payload checksum per packet,
// one result-flag pulse per packet plus saturating ok/error counters.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   WAIT_GAP | after reset, discard words until the stream shows a gap
//   IDLE     | between packets, waiting for the head word
//   PKT      | inside a packet; evaluate and pulse flags on the gap
module pkt_out_chk
  import pkt_pkg::*;
#(
  parameter logic [15:0] HEAD_WORD = HEAD_WORD_DEF,
  parameter logic [15:0] TAIL_WORD = TAIL_WORD_DEF,
  parameter int          MIN_LEN   = MIN_LEN_DEF,
  parameter int          MAX_LEN   = MAX_LEN_DEF
) (
  input logic          clk_100m,
  input logic          rst_chk,
  pkt_out_chk_if.slave bus
);

  localparam logic [7:0] MIN_LEN_W = 8'(MIN_LEN);
  localparam logic [7:0] MAX_LEN_W = 8'(MAX_LEN);

  logic        vid_d;
  logic [15:0] data_d;
  logic        in_primed;

  state_t      state;
  logic [7:0]  len;
  logic [15:0] sum_acc;
  logic [15:0] prev1;
  logic [15:0] prev2;
  logic        head_err;
  logic [7:0]  last_len;

  chk_flags_t  flags;
  chk_flags_t  eval;
  logic        pkt_done;

  always_ff @(posedge clk_100m or posedge rst_chk) begin
    if (rst_chk) begin
      vid_d     <= 1'b0;
      data_d    <= '0;
      in_primed <= 1'b0;
    end else begin
      vid_d     <= bus.vid_in;
      data_d    <= bus.data_in;
      in_primed <= 1'b1;
    end
  end

  always_comb begin
    eval           = '0;
    eval.head_err  = head_err;
    eval.short_pkt = (len < MIN_LEN_W);
    eval.long_pkt  = (len > MAX_LEN_W);
    eval.tail_err  = (len >= 8'd2) && (prev1 != TAIL_WORD);
    eval.sum_err   = (len >= 8'd4) && (prev2 != sum_acc);
    eval.ok        = ~any_err(eval);
  end

  assign pkt_done = (state == PKT) && !vid_d;

  // vid_d reads 0 straight out of reset, so the gap is only trusted once the
  // input register holds a real sample; otherwise a packet still in flight at
  // release would be picked up mid-way.
  always_ff @(posedge clk_100m or posedge rst_chk) begin
    if (rst_chk) begin
      state    <= WAIT_GAP;
      len      <= '0;
      sum_acc  <= '0;
      prev1    <= '0;
      prev2    <= '0;
      head_err <= 1'b0;
      last_len <= '0;
      flags    <= '0;
    end else begin
      flags <= '0;
      case (state)
        WAIT_GAP: begin
          if (in_primed && !vid_d) state <= IDLE;
        end
        IDLE: begin
          if (vid_d) begin
            state    <= PKT;
            head_err <= (data_d != HEAD_WORD);
            len      <= 8'd1;
            sum_acc  <= '0;
            prev1    <= data_d;
          end
        end
        PKT: begin
          if (vid_d) begin
            if (len != 8'hFF) len <= len + 8'd1;
            prev2 <= prev1;
            prev1 <= data_d;
            if (len >= 8'd3) sum_acc <= sum_acc + prev2;
          end else begin
            flags    <= eval;
            last_len <= len;
            state    <= IDLE;
          end
        end
        default: state <= WAIT_GAP;
      endcase
    end
  end

  sat_cnt #(.WIDTH(32)) u_ok_cnt (
    .clk (clk_100m),
    .rst (rst_chk),
    .inc (pkt_done && eval.ok),
    .clr (bus.cnt_clr),
    .cnt (bus.chk_ok_cnt)
  );

  sat_cnt #(.WIDTH(16)) u_err_cnt (
    .clk (clk_100m),
    .rst (rst_chk),
    .inc (pkt_done && any_err(eval)),
    .clr (bus.cnt_clr),
    .cnt (bus.chk_err_cnt)
  );

  assign bus.chk_ok        = flags.ok;
  assign bus.chk_head_err  = flags.head_err;
  assign bus.chk_tail_err  = flags.tail_err;
  assign bus.chk_sum_err   = flags.sum_err;
  assign bus.chk_short_pkt = flags.short_pkt;
  assign bus.chk_long_pkt  = flags.long_pkt;
  assign bus.chk_last_len  = last_len;

endmodule
